// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data RAM responder with req/ready wait-state handshake
//
// Purpose:
//   Responder end of the CPU data bus. Holds a 2**ADDR_WIDTH-word RAM with
//   byte-lane writes and answers each request with a one-cycle busReady pulse
//   after WAIT_STATES extra cycles. Reads return whole 32-bit words.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high
//   busReq     in   1   request valid, held by initiator until busReady
//   busWe      in   1   1 = write, 0 = read
//   busAddr    in   32  byte address
//   busWData   in   32  lane-aligned write data
//   busByteEn  in   4   write lane enables (ignored on reads)
//   busRData   out  32  registered read word, held until the next read completes
//   busReady   out  1   one-cycle completion pulse
//   busErr     out  1   error pulse alongside busReady
//
// Configuration:
//   DATA_MEM_ERR_EN  when defined, illegal lane patterns and out-of-range
//                    accesses raise busErr and are suppressed; when undefined
//                    busErr is 0 and only out-of-range accesses are filtered.

module data_mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [3:0]  busByteEn,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Counter preload; a zero-wait build never enters the wait state.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_next;

  logic [3:0]            wait_cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic                  bad_q;

  logic [31:0] mem [DEPTH];

  // Decode of the live request on the bus.
  logic [31:0]           offset;
  logic                  in_range;
  logic                  req_bad;
  logic [ADDR_WIDTH-1:0] req_idx;

  assign offset   = busAddr - BASE_ADDR;
  assign in_range = (offset[31:ADDR_WIDTH+2] == '0);
  assign req_idx  = offset[ADDR_WIDTH+1:2];

`ifdef DATA_MEM_ERR_EN
  logic lane_bad;

  // Each legal lane pattern requires a specific byte offset within the word.
  always_comb begin
    lane_bad = 1'b0;
    case (busByteEn)
      4'b0001: lane_bad = (offset[1:0] != 2'b00);
      4'b0010: lane_bad = (offset[1:0] != 2'b01);
      4'b0100: lane_bad = (offset[1:0] != 2'b10);
      4'b1000: lane_bad = (offset[1:0] != 2'b11);
      4'b0011: lane_bad = (offset[1:0] != 2'b00);
      4'b1100: lane_bad = (offset[1:0] != 2'b10);
      4'b1111: lane_bad = (offset[1:0] != 2'b00);
      default: lane_bad = 1'b1;
    endcase
  end

  assign req_bad = !in_range || (busWe && lane_bad);
`else
  // The byte offset only matters for lane checking, which is not built here.
  logic unused_offset_lsb;
  assign unused_offset_lsb = ^offset[1:0];
  assign req_bad = !in_range;
`endif

  // Transaction view used on the edge entering RESP: live bus in IDLE (zero-wait
  // path), latched copy otherwise.
  logic                  cur_we;
  logic                  cur_bad;
  logic [ADDR_WIDTH-1:0] cur_idx;

  assign cur_we  = (state == S_IDLE) ? busWe   : we_q;
  assign cur_bad = (state == S_IDLE) ? req_bad : bad_q;
  assign cur_idx = (state == S_IDLE) ? req_idx : idx_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (busReq) begin
          state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busReady = (state == S_RESP);
`ifdef DATA_MEM_ERR_EN
    busErr   = (state == S_RESP) && bad_q;
`else
    busErr   = 1'b0;
`endif
  end

  // Request capture, wait counter and read-data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      bad_q    <= 1'b0;
      busRData <= 32'd0;
    end else begin
      if (state == S_IDLE && busReq) begin
        we_q     <= busWe;
        idx_q    <= req_idx;
        wdata_q  <= busWData;
        be_q     <= busByteEn;
        bad_q    <= req_bad;
        wait_cnt <= WS_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (state_next == S_RESP && !cur_we) begin
        busRData <= cur_bad ? 32'd0 : mem[cur_idx];
      end
    end
  end

  // RAM write commits on the edge that ends RESP; gated by reset so a
  // transaction interrupted by reset never lands.
  logic mem_wr_en;
  assign mem_wr_en = (state == S_RESP) && we_q && !bad_q && !reset;

  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) begin
          mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef DATA_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];

  int total;
  int bad;

  // Index 0: WAIT_STATES=0, 1: WAIT_STATES=1, 2: WAIT_STATES=3
  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .busReq(req[0]), .busWe(we[0]), .busAddr(addr[0]),
    .busWData(wdata[0]), .busByteEn(be[0]), .busRData(rdata[0]), .busReady(ready[0]), .busErr(err[0]));
  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .busReq(req[1]), .busWe(we[1]), .busAddr(addr[1]),
    .busWData(wdata[1]), .busByteEn(be[1]), .busRData(rdata[1]), .busReady(ready[1]), .busErr(err[1]));
  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .busReq(req[2]), .busWe(we[2]), .busAddr(addr[2]),
    .busWData(wdata[2]), .busByteEn(be[2]), .busRData(rdata[2]), .busReady(ready[2]), .busErr(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete transaction; lat counts edges from the accepting edge to busReady.
  task automatic do_txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output logic [31:0] rd, output logic e, output int lat);
    repeat (2) @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ready[d] && lat < 20);
    rd = rdata[d];
    e  = err[d];
    req[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; wdata[d] = 0; be[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      total++; if (ready[d] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=0", d, ready[d]); end
      total++; if (err[d] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", d, err[d]); end
      total++; if (rdata[d] !== 32'd0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", d, rdata[d]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int lat;
    do_txn(1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, rd, e, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", e); end
    do_txn(1, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, rd, e, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_word got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic e; int lat;
    do_txn(1, 1'b1, BASE + 32'h12, 32'h00AA_0000, 4'b0100, rd, e, lat);
    do_txn(1, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, rd, e, lat);
    total++; if (rd !== 32'hDEAA_BEEF) begin bad++; $display("FAIL byte_lane got=%h exp=deaabeef", rd); end
    do_txn(1, 1'b1, BASE + 32'h12, 32'h1234_0000, 4'b1100, rd, e, lat);
    total++; if (rd !== 32'hDEAA_BEEF) begin bad++; $display("FAIL rdata_hold_on_write got=%h exp=deaabeef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL half_err got=%b exp=0", e); end
    do_txn(1, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, rd, e, lat);
    total++; if (rd !== 32'h1234_BEEF) begin bad++; $display("FAIL half_lane got=%h exp=1234beef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat; int k;
    logic [31:0] exp_d [3];
    logic exp_rdy;
    exp_d[0] = 32'h0A0A_0A0A; exp_d[1] = 32'h0B0B_0B0B; exp_d[2] = 32'h0C0C_0C0C;
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 1'b1, BASE + 32'h40 + 32'(4*i), exp_d[i], 4'b1111, rd, e, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL ws0_wr_latency[%0d] got=%0d exp=1", i, lat); end
    end
    repeat (2) @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h40;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      exp_rdy = (c % 2 == 0);
      total++; if (ready[0] !== exp_rdy) begin bad++; $display("FAIL b2b_ready[c%0d] got=%b exp=%b", c, ready[0], exp_rdy); end
      if (ready[0] === 1'b1 && k < 3) begin
        total++; if (rdata[0] !== exp_d[k]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, rdata[0], exp_d[k]); end
        k++;
        if (k < 3) addr[0] = BASE + 32'h40 + 32'(4*k);
        else req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e; int lat;
    do_txn(0, 1'b1, BASE + 32'h10, 32'h1357_9BDF, 4'b1111, rd, e, lat);
    // Aliases onto word 4 if the range check were missing.
    do_txn(0, 1'b1, BASE + 32'h1010, 32'hFFFF_FFFF, 4'b1111, rd, e, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL oor_wr_latency got=%0d exp=1", lat); end
    total++; if (e !== ERR_EN) begin bad++; $display("FAIL oor_wr_err got=%b exp=%b", e, ERR_EN); end
    do_txn(0, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, rd, e, lat);
    total++; if (rd !== 32'h1357_9BDF) begin bad++; $display("FAIL oor_wr_dropped got=%h exp=13579bdf", rd); end
    do_txn(0, 1'b0, BASE + 32'h1000, 32'h0, 4'b0000, rd, e, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL oor_rd_ready got_lat=%0d exp=1", lat); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL oor_rd_data got=%h exp=0", rd); end
    total++; if (e !== ERR_EN) begin bad++; $display("FAIL oor_rd_err got=%b exp=%b", e, ERR_EN); end
  endtask

  task automatic test_err_lanes();
    logic [31:0] rd; logic e; int lat;
    logic [31:0] exp_w;
    exp_w = ERR_EN ? 32'h5566_7788 : 32'h5566_CAFE;
    do_txn(1, 1'b1, BASE + 32'h20, 32'h5566_7788, 4'b1111, rd, e, lat);
    do_txn(1, 1'b1, BASE + 32'h21, 32'h0000_CAFE, 4'b0011, rd, e, lat);
    total++; if (e !== ERR_EN) begin bad++; $display("FAIL misaligned_err got=%b exp=%b", e, ERR_EN); end
    do_txn(1, 1'b0, BASE + 32'h20, 32'h0, 4'b0000, rd, e, lat);
    total++; if (rd !== exp_w) begin bad++; $display("FAIL misaligned_word got=%h exp=%h", rd, exp_w); end
  endtask

  task automatic test_req_drop();
    logic [31:0] rd; logic e; int lat; int n;
    do_txn(2, 1'b1, BASE + 32'h30, 32'h0F0F_0F0F, 4'b1111, rd, e, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL ws3_latency got=%0d exp=4", lat); end
    repeat (2) @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE + 32'h30; wdata[2] = 32'h7777_7777; be[2] = 4'b1111;
    @(posedge clk); #1;
    req[2] = 1'b0;
    n = 1;
    while (!ready[2] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL drop_ready got_lat=%0d exp=4", n); end
    do_txn(2, 1'b0, BASE + 32'h30, 32'h0, 4'b0000, rd, e, lat);
    total++; if (rd !== 32'h7777_7777) begin bad++; $display("FAIL drop_commit got=%h exp=77777777", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; int seen;
    repeat (2) @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE + 32'h30; wdata[2] = 32'h2222_2222; be[2] = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++; if (ready[2] !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b exp=0", ready[2]); end
    req[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    total++; if (rdata[2] !== 32'd0) begin bad++; $display("FAIL midreset_rdata got=%h exp=0", rdata[2]); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ready[2] === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_pulse got=%0d exp=0", seen); end
    do_txn(2, 1'b0, BASE + 32'h30, 32'h0, 4'b0000, rd, e, lat);
    total++; if (rd !== 32'h7777_7777) begin bad++; $display("FAIL midreset_word got=%h exp=77777777", rd); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_err_lanes();
    test_req_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
